iter_alu_zy: RTL and testbench
==============================

Name: iter_alu_zy

Overview:
- Parametrised successor to the datapath's combinational ALU with its Y and Z registers.
- Holds the Y operand register, the 2*WIDTH Z result register and an ALU.
- Single-cycle logic/shift/add ops complete in one clock; signed MUL (radix-2 Booth) and signed DIV (restoring) run iteratively over WIDTH cycles.
- Uses a start/busy/done handshake so the control unit can stall on long ops.

Parameters:
- WIDTH, 32, operand width; Z is 2*WIDTH; must be a power of 2, at least 8.
- SHW, $clog2(WIDTH), shift-amount field width taken from B[SHW-1:0].
- CNTW, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-low reset.
- bus_in  in  WIDTH  bus value; operand B and the Y load source.
- y_in  in  1  load Y from bus_in at the clock edge.
- op  in  5  opcode, sampled with start.
- start  in  1  launch op on this edge.
- y_out  out  WIDTH  current Y register.
- z_hi  out  WIDTH  Z[2W-1:W].
- z_lo  out  WIDTH  Z[W-1:0].
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle pulse: Z holds a new result.
- div_by_zero  out  1  last DIV had B==0; cleared by the next accepted start.

Behaviour:
- Reset (clr==0 at an edge): Y, Z, the counter and div_by_zero go to 0; busy=0, done=0; state goes to IDLE. Reset aborts any op in progress, and a start in the same cycle is ignored.
- Y: loads bus_in whenever y_in=1, including while busy. An active op uses its operands as snapshotted at start (A=Y, B=bus_in).
- Opcodes:
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR.
  - 4 SHR logical; 5 SHRA arithmetic; 6 SHL; 7 ROR; 8 ROL. Shift and rotate amount is B[SHW-1:0].
  - 9 NEG -B; 10 NOT ~B; 11 MUL; 12 DIV; 13 PASSB; 14 INCB B+1. 15-31 give a result of 0.
  - ADD/SUB/INCB wrap modulo 2^WIDTH with no carry output.
- Single-cycle ops (all except 11 and 12, plus DIV with B==0):
  - start accepted at edge k; Z is written at edge k with z_hi=0 and z_lo=result.
  - done=1 for the cycle after edge k; busy stays 0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE + start + op=11 -> MUL. Load product P={0, A, q-1=0} and count=0.
  - MUL: one Booth step per edge. At the edge where count reaches WIDTH, write the signed 2W product to Z and go to IDLE.
  - IDLE + start + op=12, B!=0 -> DIV. Work on |A| and |B|, with count=0.
  - DIV: one restoring step per edge; after WIDTH steps go to FIX.
  - FIX: apply signs and write Z, then go to IDLE. Quotient truncates toward zero into z_lo. Remainder takes the sign of the dividend into z_hi.
  - DIV with B==0: no iteration. Z={A, all-ones}, div_by_zero=1, handled as a single-cycle op.
  - DIV of most-negative by -1: z_lo=most-negative (wrap), z_hi=0.
- Latency, with start accepted at edge 0:
  - MUL: busy=1 after edges 1..WIDTH-1; Z written at edge WIDTH; done during the following cycle.
  - DIV: Z written at edge WIDTH+1.
  - busy falls in the same cycle that done rises.
- Z holds its previous value throughout busy and only changes at a completion edge.
- start while busy is ignored: no queueing, and no change to the snapshot or to div_by_zero.
- start in the done cycle is accepted normally; back-to-back ops are allowed.
- The op input is ignored when start=0.

Test Plan:
- Y=0x00000005, ADD with bus_in=0x0000000A -> at next edge z_lo=0x0000000F, z_hi=0; done pulses 1 cycle; busy never rises.
- Y=0xFFFFFFFD (-3), MUL with bus_in=7 -> busy for 31 cycles; at edge 32 z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB (-21); single done pulse. Also check 0x80000000 * 0x80000000 -> z_hi=0x40000000, z_lo=0.
- Y=0xFFFFFFF9 (-7), DIV with bus_in=2 -> at edge 33 z_lo=0xFFFFFFFD (-3), z_hi=0xFFFFFFFF (-1); div_by_zero=0.
- Y=0x12345678, DIV with bus_in=0 -> next edge z_lo=0xFFFFFFFF, z_hi=0x12345678, div_by_zero=1. A following ADD start clears div_by_zero.
- During MUL, pulse start with op=ADD and toggle y_in with a new bus value -> ADD ignored; MUL result unchanged; Y updated.
- Drop clr low at cycle 10 of a MUL -> at that edge Z=0, busy=0, done=0, state IDLE. Then Y=0x80000001 with ROR by B=1 -> z_lo=0xC0000000.

Source files
------------

// File: rtl/iter_alu_zy.sv
// iter_alu_zy: Y/Z register pair around an ALU. Logic, shift and add ops
// finish in one clock; signed MUL (radix-2 Booth) and signed DIV (restoring)
// iterate over WIDTH clocks behind a start/busy/done handshake.
module iter_alu_zy #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             y_in,
  input  logic [4:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [4:0]      OP_MUL = 5'd11;
  localparam logic [4:0]      OP_DIV = 5'd12;
  localparam logic [CNTW-1:0] LAST   = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] y_reg, z_hi_reg, z_lo_reg;
  logic [CNTW-1:0]  count_reg;
  logic             busy_reg, done_reg, dbz_reg;
  // Shared iteration datapath: hi_reg is the Booth accumulator (one guard bit
  // so the most-negative multiplicand never overflows) or the division
  // remainder; lo_reg is the multiplier/quotient shift register.
  logic [WIDTH:0]   hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             q_reg;
  logic [WIDTH:0]   m_reg;
  logic             neg_q_reg, neg_r_reg;

  logic [WIDTH-1:0] a, b, a_abs, b_abs;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] ror_val, rol_val, alu_res;
  logic [WIDTH:0]   booth_sum, mul_hi, r_shift, trial, div_rem;
  logic [WIDTH-1:0] mul_lo, div_quo, q_fix, r_fix;

  assign a     = y_reg;
  assign b     = bus_in;
  assign sh    = b[SHW-1:0];
  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;

  // Rotates built bit by bit so every operand bit is used directly
  always_comb begin
    ror_val = '0;
    rol_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ror_val[i] = a[(i + int'(sh)) % WIDTH];
      rol_val[i] = a[(i - int'(sh) + WIDTH) % WIDTH];
    end
  end

  // Single-cycle ALU result selected by opcode
  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:    alu_res = a + b;
      5'd1:    alu_res = a - b;
      5'd2:    alu_res = a & b;
      5'd3:    alu_res = a | b;
      5'd4:    alu_res = a >> sh;
      5'd5:    alu_res = $signed(a) >>> sh;
      5'd6:    alu_res = a << sh;
      5'd7:    alu_res = ror_val;
      5'd8:    alu_res = rol_val;
      5'd9:    alu_res = -b;
      5'd10:   alu_res = ~b;
      5'd13:   alu_res = b;
      5'd14:   alu_res = b + 1'b1;
      default: alu_res = '0;
    endcase
  end

  // One Booth step and one restoring-division step, plus the final sign fix
  always_comb begin
    case ({lo_reg[0], q_reg})
      2'b01:   booth_sum = hi_reg + m_reg;
      2'b10:   booth_sum = hi_reg - m_reg;
      default: booth_sum = hi_reg;
    endcase
    mul_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_lo  = {booth_sum[0], lo_reg[WIDTH-1:1]};
    r_shift = {hi_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
    trial   = r_shift - m_reg;
    div_rem = trial[WIDTH] ? r_shift : trial;
    div_quo = {lo_reg[WIDTH-2:0], ~trial[WIDTH]};
    q_fix   = neg_q_reg ? -lo_reg : lo_reg;
    r_fix   = neg_r_reg ? -hi_reg[WIDTH-1:0] : hi_reg[WIDTH-1:0];
  end

  // Y register loads from the bus at any time, independent of the FSM
  always_ff @(posedge clk) begin
    if (!clr) y_reg <= '0;
    else if (y_in) y_reg <= bus_in;
  end

  // Control FSM, iteration datapath and Z register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg <= IDLE;
      z_hi_reg  <= '0;
      z_lo_reg  <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      q_reg     <= 1'b0;
      m_reg     <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            dbz_reg   <= 1'b0;
            count_reg <= '0;
            if (op == OP_MUL) begin
              hi_reg    <= '0;
              lo_reg    <= a;
              q_reg     <= 1'b0;
              m_reg     <= {b[WIDTH-1], b};
              state_reg <= MUL;
            end else if (op == OP_DIV && b != '0) begin
              hi_reg    <= '0;
              lo_reg    <= a_abs;
              m_reg     <= {1'b0, b_abs};
              neg_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r_reg <= a[WIDTH-1];
              state_reg <= DIV;
            end else if (op == OP_DIV) begin
              // Divide by zero: flag it and return the dividend with all-ones quotient
              z_hi_reg <= a;
              z_lo_reg <= '1;
              dbz_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              z_hi_reg <= '0;
              z_lo_reg <= alu_res;
              done_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          hi_reg    <= mul_hi;
          lo_reg    <= mul_lo;
          q_reg     <= lo_reg[0];
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            z_hi_reg  <= mul_hi[WIDTH-1:0];
            z_lo_reg  <= mul_lo;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            busy_reg <= 1'b1;
          end
        end
        DIV: begin
          hi_reg    <= div_rem;
          lo_reg    <= div_quo;
          count_reg <= count_reg + 1'b1;
          busy_reg  <= 1'b1;
          if (count_reg == LAST) state_reg <= FIX;
        end
        FIX: begin
          z_hi_reg  <= r_fix;
          z_lo_reg  <= q_fix;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign y_out       = y_reg;
  assign z_hi        = z_hi_reg;
  assign z_lo        = z_lo_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_iter_alu_zy.sv
// Randomised and directed bench for iter_alu_zy against an arithmetic model.
module tb_iter_alu_zy;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  bus_in = '0;
  logic          y_in = 1'b0;
  logic [4:0]    op = '0;
  logic          start = 1'b0;
  logic [W-1:0]  y_out, z_hi, z_lo;
  logic          busy, done, div_by_zero;

  int n_vec = 0;
  int n_bad = 0;
  logic dbz_exp = 1'b0;

  iter_alu_zy #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .y_in(y_in), .op(op), .start(start),
    .y_out(y_out), .z_hi(z_hi), .z_lo(z_lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {z_hi, z_lo} computed from the opcode definitions
  function automatic logic [63:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [31:0] r;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    r  = '0;
    case (o)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  begin r = a; repeat (s) r = {1'b0, r[31:1]}; end
      5'd5:  begin r = a; repeat (s) r = {r[31], r[31:1]}; end
      5'd6:  begin r = a; repeat (s) r = {r[30:0], 1'b0}; end
      5'd7:  begin r = a; repeat (s) r = {r[0], r[31:1]}; end
      5'd8:  begin r = a; repeat (s) r = {r[30:0], r[31]}; end
      5'd9:  r = 32'(0) - b;
      5'd10: r = ~b;
      5'd11: return 64'(sa * sb);
      5'd12: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      5'd13: r = b;
      5'd14: r = b + 32'd1;
      default: r = '0;
    endcase
    return {32'h0, r};
  endfunction

  // Load Y, launch one op, follow it to completion and check the handshake
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input bit interfere);
    int exp_edge, exp_busy, edge_n, busy_n;
    logic [63:0] z_before, exp_z;
    logic [31:0] y_exp;
    bit zmoved;
    exp_z    = model(o, a, b);
    exp_edge = (o == 5'd11) ? W : ((o == 5'd12 && b != 0) ? W + 1 : 0);
    exp_busy = (o == 5'd11) ? W - 1 : ((o == 5'd12 && b != 0) ? W : 0);
    y_in = 1'b1; bus_in = a;
    @(posedge clk); #1;
    y_in = 1'b0;
    z_before = {z_hi, z_lo};
    bus_in = b; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 5'($urandom); bus_in = $urandom;
    y_exp = a; edge_n = 0; busy_n = 0; zmoved = 1'b0;
    while (!done && edge_n < 100) begin
      if (busy) busy_n++;
      if ({z_hi, z_lo} !== z_before) zmoved = 1'b1;
      if (interfere && edge_n == 4) begin
        start = 1'b1; op = 5'd0; y_in = 1'b1;
        bus_in = $urandom; y_exp = bus_in;
      end
      @(posedge clk); #1;
      start = 1'b0; y_in = 1'b0;
      edge_n++;
    end
    dbz_exp = (o == 5'd12 && b == 0);
    $display("op=%0d a=%h b=%h -> z=%h%h edges=%0d", o, a, b, z_hi, z_lo, edge_n);
    check("latency", 64'(edge_n), 64'(exp_edge));
    check("busy_cycles", 64'(busy_n), 64'(exp_busy));
    check("z_hold", 64'(zmoved), 64'd0);
    check("z", {z_hi, z_lo}, exp_z);
    check("div_by_zero", 64'(div_by_zero), 64'(dbz_exp));
    check("y", 64'(y_out), 64'(y_exp));
    check("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", {z_hi, z_lo}, 64'd0);
    check("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("rst_y", 64'(y_out), 64'd0);
    clr = 1'b1;

    run_op(5'd0,  32'h0000_0005, 32'h0000_000A, 1'b0);
    run_op(5'd11, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    run_op(5'd11, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(5'd12, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(5'd12, 32'h1234_5678, 32'h0000_0000, 1'b0);
    run_op(5'd0,  32'h0000_0001, 32'h0000_0002, 1'b0);
    run_op(5'd11, $urandom, $urandom, 1'b1);
    run_op(5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(5'd12, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

    // Back-to-back: a second start in the done cycle of the first
    y_in = 1'b1; bus_in = 32'd5;
    @(posedge clk); #1;
    y_in = 1'b0; bus_in = 32'd10; op = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_z1", {z_hi, z_lo}, model(5'd0, 32'd5, 32'd10));
    bus_in = 32'd3; op = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_z2", {z_hi, z_lo}, model(5'd1, 32'd5, 32'd3));
    $display("back-to-back ADD/SUB z=%h%h", z_hi, z_lo);

    // Reset in the middle of a MUL, with a start on the same edge
    y_in = 1'b1; bus_in = 32'h0000_1234;
    @(posedge clk); #1;
    y_in = 1'b0; bus_in = 32'd5; op = 5'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    clr = 1'b0; start = 1'b1; op = 5'd0;
    @(posedge clk); #1;
    clr = 1'b1; start = 1'b0;
    $display("reset mid-MUL z=%h%h busy=%0d done=%0d", z_hi, z_lo, busy, done);
    check("rst2_z", {z_hi, z_lo}, 64'd0);
    check("rst2_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(posedge clk); #1;
    check("rst2_idle", {62'd0, busy, done}, 64'd0);
    dbz_exp = 1'b0;
    run_op(5'd7, 32'h8000_0001, 32'h0000_0001, 1'b0);

    // Random mix, weighted toward the iterative ops and corner operands
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: ro = 5'd11;
        1: ro = 5'd12;
        default: ro = 5'($urandom_range(0, 31));
      endcase
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd0;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) && (ro == 5'd11));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
